// File: rtl/conv_engine.sv
// conv_engine: sequences full linear convolution z[n] = sum x[k]*y[n-k]
// from the X/Y sample memories into the Z memory, one MAC every two cycles.
module conv_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  localparam int ZW = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   sizeX,
  input  logic [ADDR_WIDTH:0]   sizeY,
  output logic [ADDR_WIDTH-1:0] memX_addr,
  output logic                  memX_rd,
  input  logic [DATA_WIDTH-1:0] memX_data,
  output logic [ADDR_WIDTH-1:0] memY_addr,
  output logic                  memY_rd,
  input  logic [DATA_WIDTH-1:0] memY_data,
  output logic [ADDR_WIDTH:0]   memZ_addr,
  output logic [ZW-1:0]         memZ_data,
  output logic                  memZ_wr,
  output logic                  busy,
  output logic                  done
);
  localparam int SW = ADDR_WIDTH + 1;
  localparam logic [SW-1:0] MAXS = SW'(2**ADDR_WIDTH);
  localparam logic [SW-1:0] ONE = SW'(1);
  typedef enum logic [2:0] {IDLE, INIT, READ, MAC, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [SW-1:0] sx, sy, n, kmin, kmax, nlast, cx, cy;
  logic [ADDR_WIDTH-1:0] k;
  logic [ZW-1:0] acc;
  logic last_k, last_n;
  // k window for output n: only indices where both x[k] and y[n-k] exist
  always_comb begin
    cx = sizeX > MAXS ? MAXS : sizeX;
    cy = sizeY > MAXS ? MAXS : sizeY;
    kmin = n > sy - ONE ? n - (sy - ONE) : '0;
    kmax = n < sx - ONE ? n : sx - ONE;
    nlast = sx + sy - SW'(2);
    last_k = SW'(k) == kmax;
    last_n = n == nlast;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !start ? IDLE : (sizeX == '0 || sizeY == '0) ? DONE : INIT;
      INIT:    nxt = READ;
      READ:    nxt = MAC;
      MAC:     nxt = last_k ? WRITE : READ;
      WRITE:   nxt = last_n ? DONE : INIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sx <= '0;
      sy <= '0;
      n <= '0;
      k <= '0;
      acc <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        sx <= cx;
        sy <= cy;
        n <= '0;
      end
      if (state == INIT) begin
        acc <= '0;
        k <= ADDR_WIDTH'(kmin);
      end
      if (state == MAC) begin
        acc <= acc + ZW'(memX_data) * ZW'(memY_data);
        if (!last_k) k <= k + ADDR_WIDTH'(1);
      end
      if (state == WRITE && !last_n) n <= n + ONE;
    end
  end
  always_comb begin
    memX_rd = state == READ;
    memY_rd = state == READ;
    memZ_wr = state == WRITE;
    memX_addr = memX_rd ? k : '0;
    memY_addr = memY_rd ? ADDR_WIDTH'(n - SW'(k)) : '0;
    memZ_addr = memZ_wr ? n : '0;
    memZ_data = memZ_wr ? acc : '0;
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed runs checked every cycle against a convolution
// model built from nested sums, plus hand-computed literal results.
module tb_conv_engine;
  logic        clk = 0;
  logic        rst, start;
  logic [3:0]  sizeX, sizeY;
  logic [2:0]  memX_addr, memY_addr;
  logic        memX_rd, memY_rd, memZ_wr, busy, done;
  logic [7:0]  memX_data = 0, memY_data = 0;
  logic [3:0]  memZ_addr;
  logic [18:0] memZ_data;

  conv_engine dut (
    .clk(clk), .rst(rst), .start(start), .sizeX(sizeX), .sizeY(sizeY),
    .memX_addr(memX_addr), .memX_rd(memX_rd), .memX_data(memX_data),
    .memY_addr(memY_addr), .memY_rd(memY_rd), .memY_data(memY_data),
    .memZ_addr(memZ_addr), .memZ_data(memZ_data), .memZ_wr(memZ_wr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] xm[8], ym[8];
  always @(posedge clk) begin
    if (memX_rd) memX_data <= xm[memX_addr];
    if (memY_rd) memY_data <= ym[memY_addr];
  end

  int checks = 0, errors = 0;
  int msx, msy, nout, exp_done, cyc, wr_cnt, rd_cnt;
  bit active = 0;
  longint exp_z[16], act_z[16];
  int exp_wcyc[16], terms[16];

  task automatic chk(string nm, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  // z[n] as the sum over every (k,j) pair with k+j=n; write cycles from term counts
  task automatic model(int sx, int sy);
    int t;
    msx = sx > 8 ? 8 : sx;
    msy = sy > 8 ? 8 : sy;
    nout = (msx > 0 && msy > 0) ? msx + msy - 1 : 0;
    for (int i = 0; i < 16; i++) begin
      exp_z[i] = 0;
      terms[i] = 0;
    end
    for (int i = 0; i < msx; i++)
      for (int j = 0; j < msy; j++) begin
        exp_z[i+j] += longint'(xm[i]) * longint'(ym[j]);
        terms[i+j]++;
      end
    t = 0;
    for (int i = 0; i < nout; i++) begin
      t += 2 * terms[i] + 2;
      exp_wcyc[i] = t;
    end
    exp_done = nout > 0 ? t + 1 : 1;
  endtask

  always @(negedge clk) begin
    if (active) begin
      cyc++;
      chk("busy", busy, cyc <= exp_done);
      chk("done", done, cyc == exp_done);
      if (memX_rd) begin
        rd_cnt++;
        chk("rd pair", memY_rd, 1);
        chk("x addr range", memX_addr < msx, 1);
        chk("y addr range", memY_addr < msy, 1);
        chk("k+j index", int'(memX_addr) + int'(memY_addr), wr_cnt);
      end
      if (memZ_wr) begin
        chk("z addr", memZ_addr, wr_cnt);
        chk("z data", memZ_data, exp_z[wr_cnt]);
        chk("z cycle", cyc, exp_wcyc[wr_cnt]);
        act_z[wr_cnt] = memZ_data;
        wr_cnt++;
      end
      if (cyc == exp_done + 1) begin
        chk("write count", wr_cnt, nout);
        chk("read count", rd_cnt, msx * msy);
        active = 0;
      end
    end else begin
      chk("idle busy", busy, 0);
      chk("idle done", done, 0);
      chk("idle rd", memX_rd | memY_rd, 0);
      chk("idle wr", memZ_wr, 0);
    end
    if (!memX_rd) chk("x addr idle", memX_addr, 0);
    if (!memY_rd) chk("y addr idle", memY_addr, 0);
    if (!memZ_wr) chk("z idle", {memZ_addr, memZ_data}, 0);
  end

  task automatic run(int sx, int sy, int extra_at, int abort_at);
    int c;
    bit ab;
    model(sx, sy);
    for (int i = 0; i < 16; i++) act_z[i] = -1;
    wr_cnt = 0;
    rd_cnt = 0;
    sizeX = 4'(sx);
    sizeY = 4'(sy);
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    cyc = 0;
    active = 1;
    #1 start = 0;
    c = 1;
    ab = 0;
    while (active && c < 600 && !ab) begin
      if (c == 2) begin
        sizeX = 4'd1;
        sizeY = 4'd8;
      end
      start = (c == extra_at);
      if (c == abort_at) begin
        active = 0;
        rst = 1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort rd", memX_rd | memY_rd, 0);
        chk("abort addr", {memX_addr, memY_addr}, 0);
        chk("abort z", {memZ_wr, memZ_addr, memZ_data}, 0);
        chk("abort partial writes", wr_cnt, 1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        ab = 1;
      end else begin
        @(posedge clk);
        #1 c++;
      end
    end
    start = 0;
    if (active) begin
      checks++;
      errors++;
      $display("FAIL run timeout: no completion within %0d cycles", c);
      active = 0;
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < 8; i++) begin
      xm[i] = 0;
      ym[i] = 0;
    end
    xm[0] = 1; xm[1] = 2; xm[2] = 3;
    ym[0] = 1; ym[1] = 1;
  endtask

  task automatic chk_basic(string tag);
    chk({tag, " z0"}, act_z[0], 1);
    chk({tag, " z1"}, act_z[1], 3);
    chk({tag, " z2"}, act_z[2], 5);
    chk({tag, " z3"}, act_z[3], 3);
  endtask

  initial begin
    rst = 1;
    start = 0;
    sizeX = 0;
    sizeY = 0;
    for (int i = 0; i < 8; i++) begin
      xm[i] = 0;
      ym[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset outputs", {memX_rd, memY_rd, memZ_wr, memX_addr, memY_addr, memZ_addr, memZ_data}, 0);
    rst = 0;

    xm[0] = 3; ym[0] = 4;
    run(1, 1, 0, 0);
    chk("1x1 model z0", exp_z[0], 12);
    chk("1x1 model done", exp_done, 5);
    chk("1x1 z0", act_z[0], 12);

    set_basic();
    run(3, 2, 0, 0);
    chk("basic model z1", exp_z[1], 3);
    chk("basic model done", exp_done, 21);
    chk_basic("basic");

    run(3, 2, 10, 0);
    chk_basic("restart ignored");

    for (int i = 0; i < 8; i++) begin
      xm[i] = 8'hFF;
      ym[i] = 8'hFF;
    end
    run(8, 8, 0, 0);
    chk("max model done", exp_done, 159);
    chk("max z0", act_z[0], 65025);
    chk("max z7", act_z[7], 520200);
    chk("max z14", act_z[14], 65025);

    run(0, 5, 0, 0);
    chk("zero model done", exp_done, 1);

    for (int i = 0; i < 8; i++) xm[i] = 8'(i + 1);
    ym[0] = 2;
    run(12, 1, 0, 0);
    chk("clamp model done", exp_done, 33);
    chk("clamp z7", act_z[7], 16);

    set_basic();
    run(3, 2, 0, 7);
    chk("abort kept z0", act_z[0], 1);
    run(3, 2, 0, 0);
    chk_basic("after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
